// File: rtl/priority_event_queue.sv
// Priority event queue: captures event pulses into a pending vector and issues one index per transfer.
// Latency: set_i at edge t shows on pending_o after t; the index is issued on valid_o/idx_o after edge t+1.
// Backpressure: while valid_o && !ready_i the output register holds and new events keep accumulating.
module priority_event_queue #(
   parameter int WIDTH   = 32,
   parameter int IDX_W   = $clog2(WIDTH),
   parameter bit RR_MODE = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] set_i,
   input  logic [WIDTH-1:0] clr_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o,
   output logic [WIDTH-1:0] pending_o,
   output logic [IDX_W:0]   count_o
);

   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] pend_next;
   logic [WIDTH-1:0] issue_mask;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] sel;
   logic [IDX_W-1:0] sel_lo;
   logic [IDX_W-1:0] sel_rr;
   logic             found_rr;
   logic             load;
   logic [IDX_W:0]   cnt_next;

   // Find the lowest pending index overall and the lowest one at or above the round-robin pointer.
   always_comb begin
      sel_lo   = '0;
      sel_rr   = '0;
      found_rr = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel_lo = IDX_W'(i);
         end
         if (pend[i] && (i >= int'(ptr))) begin
            sel_rr   = IDX_W'(i);
            found_rr = 1'b1;
         end
      end
   end

   // Round-robin falls back to the overall lowest index when nothing sits at or above the pointer.
   assign sel        = (RR_MODE && found_rr) ? sel_rr : sel_lo;
   assign load       = (!valid_o || ready_i) && (|pend);
   assign issue_mask = load ? ({{(WIDTH-1){1'b0}}, 1'b1} << sel) : '0;
   // Set is applied last so a bit re-raised in its issue cycle stays pending as a fresh event.
   assign pend_next  = (pend & ~clr_i & ~issue_mask) | set_i;

   // Population count of the next pending vector, registered together with it.
   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next = cnt_next + (IDX_W+1)'(pend_next[i]);
      end
   end

   // Pending vector and its population count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend    <= '0;
         count_o <= '0;
      end else begin
         pend    <= pend_next;
         count_o <= cnt_next;
      end
   end

   assign pending_o = pend;

   // Output register: load a new index whenever the slot is free or being drained.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         idx_o   <= '0;
      end else if (load) begin
         valid_o <= 1'b1;
         idx_o   <= sel;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

   // Round-robin pointer moves just past the issued index, wrapping at the top.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else if (RR_MODE && load) begin
         if (sel == IDX_W'(WIDTH - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= sel + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_priority_event_queue.sv
// Bench for priority_event_queue: a fixed-priority and a round-robin instance share one stimulus stream.
// Directed scenarios check exact index sequences; a random phase compares against a queue-level model.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there as well.
module tb_priority_event_queue;
   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic [W-1:0]  set_i;
   logic [W-1:0]  clr_i;
   logic          ready_i;
   logic          dv [2];
   logic [4:0]    di [2];
   logic [W-1:0]  dp [2];
   logic [5:0]    dc [2];

   int n_cmp;
   int n_err;

   // Reference state per mode: pending set, output slot and round-robin pointer.
   bit [W-1:0] mp   [2];
   bit         mv   [2];
   int         mi   [2];
   int         mptr [2];

   priority_event_queue #(.WIDTH(W), .RR_MODE(1'b0)) u_fix (
      .clk_i(clk), .rst_i(rst), .set_i(set_i), .clr_i(clr_i), .ready_i(ready_i),
      .valid_o(dv[0]), .idx_o(di[0]), .pending_o(dp[0]), .count_o(dc[0]));

   priority_event_queue #(.WIDTH(W), .RR_MODE(1'b1)) u_rr (
      .clk_i(clk), .rst_i(rst), .set_i(set_i), .clr_i(clr_i), .ready_i(ready_i),
      .valid_o(dv[1]), .idx_o(di[1]), .pending_o(dp[1]), .count_o(dc[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mp[m] = '0; mv[m] = 1'b0; mi[m] = 0; mptr[m] = 0;
      end
   endtask

   // One clock of behaviour: circular search from the start point picks the next event to issue.
   task automatic model_step(input logic [W-1:0] s, input logic [W-1:0] c, input logic r);
      for (int m = 0; m < 2; m++) begin
         bit ld, found;
         int sel, start, j;
         bit [W-1:0] np;
         ld = (!mv[m] || r) && (mp[m] != 0);
         sel = 0;
         found = 1'b0;
         start = (m == 1) ? mptr[m] : 0;
         for (int k = 0; k < W; k++) begin
            j = (start + k) % W;
            if (!found && mp[m][j]) begin
               sel = j;
               found = 1'b1;
            end
         end
         np = mp[m] & ~c;
         if (ld) np[sel] = 1'b0;
         np = np | s;
         if (ld) begin
            mv[m] = 1'b1;
            mi[m] = sel;
            if (m == 1) mptr[m] = (sel + 1) % W;
         end else if (mv[m] && r) begin
            mv[m] = 1'b0;
         end
         mp[m] = np;
      end
   endtask

   task automatic cycle(input logic [W-1:0] s, input logic [W-1:0] c, input logic r);
      set_i = s; clr_i = c; ready_i = r;
      model_step(s, c, r);
      @(posedge clk);
      #1;
      set_i = '0; clr_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; set_i = '0; clr_i = '0; ready_i = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; set_i = '0; clr_i = '0; ready_i = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", m, dv[m]); end
         n_cmp++; if (di[m] !== 5'd0) begin n_err++; $display("FAIL reset_idx[%0d]: got %0d want 0", m, di[m]); end
         n_cmp++; if (dp[m] !== '0) begin n_err++; $display("FAIL reset_pending[%0d]: got %h want 0", m, dp[m]); end
         n_cmp++; if (dc[m] !== 6'd0) begin n_err++; $display("FAIL reset_count[%0d]: got %0d want 0", m, dc[m]); end
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      cycle(32'h1, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dp[m] !== 32'h1) begin n_err++; $display("FAIL single_pending[%0d]: got %h want 1", m, dp[m]); end
         n_cmp++; if (dc[m] !== 6'd1) begin n_err++; $display("FAIL single_count1[%0d]: got %0d want 1", m, dc[m]); end
         n_cmp++; if (dv[m] !== 1'b0) begin n_err++; $display("FAIL single_early_valid[%0d]: got %b want 0", m, dv[m]); end
      end
      cycle('0, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b want 1", m, dv[m]); end
         n_cmp++; if (di[m] !== 5'd0) begin n_err++; $display("FAIL single_idx[%0d]: got %0d want 0", m, di[m]); end
         n_cmp++; if (dc[m] !== 6'd0) begin n_err++; $display("FAIL single_count0[%0d]: got %0d want 0", m, dc[m]); end
      end
      cycle('0, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b0) begin n_err++; $display("FAIL single_drop[%0d]: got %b want 0", m, dv[m]); end
      end
   endtask

   // Fixed mode issues 0,4,31; round-robin starts past the previously issued 0.
   task automatic test_fixed_order();
      int e0 [3] = '{0, 4, 31};
      int e1 [3] = '{4, 31, 0};
      cycle(32'h8000_0011, '0, 1'b1);
      n_cmp++; if (dc[0] !== 6'd3) begin n_err++; $display("FAIL order_count: got %0d want 3", dc[0]); end
      for (int k = 0; k < 3; k++) begin
         cycle('0, '0, 1'b1);
         n_cmp++; if (dv[0] !== 1'b1 || di[0] !== 5'(e0[k])) begin n_err++; $display("FAIL order_fix[%0d]: got v=%b idx=%0d want v=1 idx=%0d", k, dv[0], di[0], e0[k]); end
         n_cmp++; if (dv[1] !== 1'b1 || di[1] !== 5'(e1[k])) begin n_err++; $display("FAIL order_rr[%0d]: got v=%b idx=%0d want v=1 idx=%0d", k, dv[1], di[1], e1[k]); end
      end
      cycle('0, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b0) begin n_err++; $display("FAIL order_empty[%0d]: got %b want 0", m, dv[m]); end
      end
   endtask

   // Re-raising bit 0 while it issues: round-robin yields 0,2,0 where fixed yields 0,0,2.
   task automatic test_rr_wrap();
      int e0 [3] = '{0, 0, 2};
      int e1 [3] = '{0, 2, 0};
      do_reset();
      cycle(32'h5, '0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle((k == 0) ? 32'h1 : 32'h0, '0, 1'b1);
         n_cmp++; if (dv[0] !== 1'b1 || di[0] !== 5'(e0[k])) begin n_err++; $display("FAIL rr_fix[%0d]: got v=%b idx=%0d want v=1 idx=%0d", k, dv[0], di[0], e0[k]); end
         n_cmp++; if (dv[1] !== 1'b1 || di[1] !== 5'(e1[k])) begin n_err++; $display("FAIL rr_wrap[%0d]: got v=%b idx=%0d want v=1 idx=%0d", k, dv[1], di[1], e1[k]); end
         if (k == 0) begin
            n_cmp++; if (dp[1] !== 32'h5) begin n_err++; $display("FAIL rr_repend: got %h want 5", dp[1]); end
         end
      end
      cycle('0, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b0) begin n_err++; $display("FAIL rr_empty[%0d]: got %b want 0", m, dv[m]); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      cycle(32'h8, '0, 1'b0);
      cycle('0, '0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(32'h2, '0, 1'b0);
         for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dv[m] !== 1'b1 || di[m] !== 5'd3) begin n_err++; $display("FAIL bp_hold[%0d][%0d]: got v=%b idx=%0d want v=1 idx=3", m, k, dv[m], di[m]); end
         end
      end
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dp[m] !== 32'h2) begin n_err++; $display("FAIL bp_pending[%0d]: got %h want 2", m, dp[m]); end
         n_cmp++; if (dc[m] !== 6'd1) begin n_err++; $display("FAIL bp_count[%0d]: got %0d want 1", m, dc[m]); end
      end
      cycle('0, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b1 || di[m] !== 5'd1) begin n_err++; $display("FAIL bp_release[%0d]: got v=%b idx=%0d want v=1 idx=1", m, dv[m], di[m]); end
      end
      cycle('0, '0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b0) begin n_err++; $display("FAIL bp_empty[%0d]: got %b want 0", m, dv[m]); end
      end
   endtask

   task automatic test_set_clr();
      do_reset();
      cycle(32'h1, '0, 1'b0);
      cycle(32'h40, '0, 1'b0);
      // Collide on bit 5, cancel bit 6, and try to cancel the already issued bit 0.
      cycle(32'h20, 32'h61, 1'b0);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dp[m] !== 32'h20) begin n_err++; $display("FAIL sc_pending[%0d]: got %h want 20", m, dp[m]); end
         n_cmp++; if (dv[m] !== 1'b1 || di[m] !== 5'd0) begin n_err++; $display("FAIL sc_issued_kept[%0d]: got v=%b idx=%0d want v=1 idx=0", m, dv[m], di[m]); end
      end
      for (int k = 0; k < 4; k++) begin
         cycle('0, '0, 1'b1);
         for (int m = 0; m < 2; m++) begin
            if (k == 0) begin
               n_cmp++; if (dv[m] !== 1'b1 || di[m] !== 5'd5) begin n_err++; $display("FAIL sc_issue5[%0d]: got v=%b idx=%0d want v=1 idx=5", m, dv[m], di[m]); end
            end else begin
               n_cmp++; if (dv[m] !== 1'b0) begin n_err++; $display("FAIL sc_no6[%0d][%0d]: got v=%b idx=%0d want v=0", m, k, dv[m], di[m]); end
            end
         end
      end
   endtask

   task automatic test_full();
      do_reset();
      cycle('1, '0, 1'b0);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dc[m] !== 6'd32) begin n_err++; $display("FAIL full_count[%0d]: got %0d want 32", m, dc[m]); end
         n_cmp++; if (dp[m] !== '1) begin n_err++; $display("FAIL full_pending[%0d]: got %h want ffffffff", m, dp[m]); end
      end
      cycle('0, '0, 1'b0);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dc[m] !== 6'd31) begin n_err++; $display("FAIL full_count31[%0d]: got %0d want 31", m, dc[m]); end
      end
      cycle('1, '0, 1'b0);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dc[m] !== 6'd32) begin n_err++; $display("FAIL full_merge[%0d]: got %0d want 32", m, dc[m]); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(32'h100, '0, 1'b0);
      cycle(32'hFF, '0, 1'b0);
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b1 || di[m] !== 5'd8 || dp[m] !== 32'hFF) begin n_err++; $display("FAIL ar_pre[%0d]: got v=%b idx=%0d p=%h want v=1 idx=8 p=ff", m, dv[m], di[m], dp[m]); end
      end
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         n_cmp++; if (dv[m] !== 1'b0 || di[m] !== 5'd0) begin n_err++; $display("FAIL ar_out[%0d]: got v=%b idx=%0d want v=0 idx=0", m, dv[m], di[m]); end
         n_cmp++; if (dp[m] !== '0 || dc[m] !== 6'd0) begin n_err++; $display("FAIL ar_pend[%0d]: got p=%h c=%0d want 0", m, dp[m], dc[m]); end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle('0, '0, 1'b1);
         for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dv[m] !== 1'b0 || dp[m] !== '0) begin n_err++; $display("FAIL ar_after[%0d][%0d]: got v=%b p=%h want v=0 p=0", m, k, dv[m], dp[m]); end
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] s, c;
      logic r;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         s = $urandom & $urandom & $urandom;
         c = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
         if ($urandom_range(0, 49) == 0) s = '1;
         r = ($urandom_range(0, 3) != 0);
         cycle(s, c, r);
         for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dv[m] !== mv[m]) begin n_err++; $display("FAIL rnd_valid[%0d] @%0d: got %b want %b", m, n, dv[m], mv[m]); end
            n_cmp++; if (di[m] !== 5'(mi[m])) begin n_err++; $display("FAIL rnd_idx[%0d] @%0d: got %0d want %0d", m, n, di[m], mi[m]); end
            n_cmp++; if (dp[m] !== mp[m]) begin n_err++; $display("FAIL rnd_pending[%0d] @%0d: got %h want %h", m, n, dp[m], mp[m]); end
            n_cmp++; if (dc[m] !== 6'($countones(mp[m]))) begin n_err++; $display("FAIL rnd_count[%0d] @%0d: got %0d want %0d", m, n, dc[m], $countones(mp[m])); end
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_fixed_order();
      test_rr_wrap();
      test_backpressure();
      test_set_clr();
      test_full();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
